// File: rtl/paddle_cmd_rx.sv
// paddle_cmd_rx: turns 4-byte command packets (HDR, PLAYER, CMD, CHK) from a
// received payload stream into left/right paddle keycodes. Each command is
// held for HOLD_FRAMES frame ticks and then falls back to idle (8'h00).
module paddle_cmd_rx #(
    parameter logic [7:0]  HDR         = 8'hA5,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    input  logic        frame_tick,
    output logic [7:0]  keycode_left,
    output logic [7:0]  keycode_right,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_PLAYER = 3'd1,
        ST_GET_CMD    = 3'd2,
        ST_GET_CHK    = 3'd3,
        ST_COMMIT     = 3'd4,
        ST_DRAIN      = 3'd5
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES);

    // Packet check byte: XOR of the three leading bytes.
    function automatic logic [7:0] pkt_chk(input logic [7:0] hdr,
                                           input logic [7:0] player,
                                           input logic [7:0] cmd);
        return hdr ^ player ^ cmd;
    endfunction

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    state_t      state_r;
    logic [7:0]  player_r;
    logic [7:0]  cmd_r;
    logic        pkt_ok_r;
    logic        pkt_err_r;
    logic [15:0] err_count_r;
    logic [7:0]  key_left_r;
    logic [7:0]  key_right_r;
    logic [7:0]  hold_left_r;
    logic [7:0]  hold_right_r;

    logic xfer_s;
    logic commit_left_s;
    logic commit_right_s;

    // The only state that refuses bytes is the single commit cycle.
    assign rx_ready       = (state_r != ST_COMMIT);
    assign xfer_s         = rx_valid && rx_ready;
    assign commit_left_s  = (state_r == ST_COMMIT) && (player_r == 8'd0);
    assign commit_right_s = (state_r == ST_COMMIT) && (player_r == 8'd1);

    assign keycode_left  = key_left_r;
    assign keycode_right = key_right_r;
    assign pkt_ok        = pkt_ok_r;
    assign pkt_err       = pkt_err_r;
    assign err_count     = err_count_r;

    // Packet parser FSM with registered ok/error pulses and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            player_r    <= 8'h00;
            cmd_r       <= 8'h00;
            pkt_ok_r    <= 1'b0;
            pkt_err_r   <= 1'b0;
            err_count_r <= 16'h0000;
        end else begin
            pkt_ok_r  <= 1'b0;
            pkt_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        if ((rx_data == HDR) && !rx_last) begin
                            state_r <= ST_GET_PLAYER;
                        end else begin
                            pkt_err_r   <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            // A bad header mid-packet must swallow the rest quietly.
                            state_r     <= ((rx_data != HDR) && !rx_last) ? ST_DRAIN : ST_IDLE;
                        end
                    end
                end
                ST_GET_PLAYER: begin
                    if (xfer_s) begin
                        player_r <= rx_data;
                        if (rx_last) begin
                            pkt_err_r   <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_GET_CMD;
                        end
                    end
                end
                ST_GET_CMD: begin
                    if (xfer_s) begin
                        cmd_r <= rx_data;
                        if (rx_last) begin
                            pkt_err_r   <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r <= ST_GET_CHK;
                        end
                    end
                end
                ST_GET_CHK: begin
                    if (xfer_s) begin
                        if (!rx_last) begin
                            pkt_err_r   <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            state_r     <= ST_DRAIN;
                        end else if ((player_r > 8'd1) || (cmd_r > 8'd2) ||
                                     (rx_data != pkt_chk(HDR, player_r, cmd_r))) begin
                            pkt_err_r   <= 1'b1;
                            err_count_r <= sat_inc(err_count_r);
                            state_r     <= ST_IDLE;
                        end else begin
                            // Pulse lines up with the commit cycle itself.
                            pkt_ok_r <= 1'b1;
                            state_r  <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (xfer_s && rx_last) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-player keycode hold: commit reloads (and beats a same-cycle tick),
    // otherwise each frame tick counts down and clears the keycode at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_left_r   <= 8'h00;
            key_right_r  <= 8'h00;
            hold_left_r  <= 8'h00;
            hold_right_r <= 8'h00;
        end else begin
            if (commit_left_s) begin
                key_left_r  <= cmd_r;
                hold_left_r <= HOLD_LOAD;
            end else if (frame_tick && (hold_left_r != 8'h00)) begin
                hold_left_r <= hold_left_r - 8'd1;
                if (hold_left_r == 8'd1) begin
                    key_left_r <= 8'h00;
                end
            end
            if (commit_right_s) begin
                key_right_r  <= cmd_r;
                hold_right_r <= HOLD_LOAD;
            end else if (frame_tick && (hold_right_r != 8'h00)) begin
                hold_right_r <= hold_right_r - 8'd1;
                if (hold_right_r == 8'd1) begin
                    key_right_r <= 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle_cmd_rx.sv
// Scoreboard bench for paddle_cmd_rx: packet-level reference model, directed
// scenarios followed by randomized packets, and an error-counter saturation run.
module tb_paddle_cmd_rx;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;
    logic        frame_tick;
    logic [7:0]  keycode_left;
    logic [7:0]  keycode_right;
    logic        pkt_ok;
    logic        pkt_err;
    logic [15:0] err_count;

    paddle_cmd_rx #(.HDR(HDR), .HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_last(rx_last), .rx_ready(rx_ready), .frame_tick(frame_tick),
        .keycode_left(keycode_left), .keycode_right(keycode_right),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [15:0] cnt;
        int          player;
        logic [7:0]  cmd;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pkt_q[$];
    logic [7:0]  m_key[2];
    int          m_hold[2];
    logic [15:0] m_err;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mk(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                      input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                      input logic [7:0] b4 = 8'h00);
        pkt_q.delete();
        if (n > 0) pkt_q.push_back(b0);
        if (n > 1) pkt_q.push_back(b1);
        if (n > 2) pkt_q.push_back(b2);
        if (n > 3) pkt_q.push_back(b3);
        if (n > 4) pkt_q.push_back(b4);
    endtask

    // A packet is good only if it is exactly four bytes with valid fields.
    function automatic bit pkt_good();
        if (pkt_q.size() != 4) return 1'b0;
        return (pkt_q[0] == HDR) && (pkt_q[1] <= 8'd1) && (pkt_q[2] <= 8'd2) &&
               (pkt_q[3] == (pkt_q[0] ^ pkt_q[1] ^ pkt_q[2]));
    endfunction

    task automatic model_tick_one(input int p);
        if (m_hold[p] > 0) begin
            m_hold[p]--;
            if (m_hold[p] == 0) m_key[p] = 8'h00;
        end
    endtask

    task automatic model_reset();
        m_key[0] = 8'h00; m_key[1] = 8'h00;
        m_hold[0] = 0;    m_hold[1] = 0;
        m_err = 16'h0000;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        rx_last  = 1'($urandom);
        repeat (n) @(negedge clk);
        rx_last  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int waitc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_last  = l;
        while (!rx_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    // Expectation is queued before any byte goes out, so an early error pulse
    // always finds its entry waiting.
    task automatic send_pkt(input bit gaps, input bit tick_in_commit);
        exp_t e;
        e.ok = pkt_good();
        if (e.ok) begin
            e.player = int'(pkt_q[1]);
            e.cmd    = pkt_q[2];
            m_key[e.player]  = pkt_q[2];
            m_hold[e.player] = HOLD;
            if (tick_in_commit) model_tick_one(1 - e.player);
        end else begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            e.player = 0;
            e.cmd    = 8'h00;
        end
        e.cnt = m_err;
        exp_q.push_back(e);
        foreach (pkt_q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_byte(pkt_q[i], (i == pkt_q.size() - 1));
        end
        if (tick_in_commit) begin
            chk("rx_ready_in_commit", 16'(rx_ready), 16'h0000);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick_one(0);
        model_tick_one(1);
        chk("keycode_left_tick", 16'(keycode_left), 16'(m_key[0]));
        chk("keycode_right_tick", 16'(keycode_right), 16'(m_key[1]));
    endtask

    task automatic check_keys(input string tag);
        chk({"keycode_left_", tag}, 16'(keycode_left), 16'(m_key[0]));
        chk({"keycode_right_", tag}, 16'(keycode_right), 16'(m_key[1]));
    endtask

    task automatic pkt_and_check(input string tag);
        send_pkt(1'b1, 1'b0);
        idle(2);
        check_keys(tag);
    endtask

    // Monitor: pops the scoreboard on every ok/error pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (pkt_ok === 1'b1 || pkt_err === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got ok=%b err=%b expected no pulse", pkt_ok, pkt_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt_ok", 16'(pkt_ok), 16'(e.ok));
                    chk("pkt_err", 16'(pkt_err), 16'(!e.ok));
                    chk("err_count", err_count, e.cnt);
                    if (e.ok) begin
                        @(negedge clk);
                        chk("keycode_after_commit",
                            16'((e.player == 1) ? keycode_right : keycode_left), 16'(e.cmd));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] p, c, b[5];
        int n;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0; frame_tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_keys("reset");
        chk("pkt_ok_reset", 16'(pkt_ok), 16'h0000);
        chk("pkt_err_reset", 16'(pkt_err), 16'h0000);
        chk("err_count_reset", err_count, 16'h0000);
        chk("rx_ready_idle", 16'(rx_ready), 16'h0001);
        rst_n = 1'b1;
        @(negedge clk);

        // Held command, then reset in the middle of a packet.
        mk(4, 8'hA5, 8'h00, 8'h01, 8'hA4);
        pkt_and_check("pre_reset");
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_keys("mid_reset");
        chk("err_count_mid_reset", err_count, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Right-player commit; rx_ready drops only for the commit cycle.
        mk(4, 8'hA5, 8'h01, 8'h02, 8'hA6);
        send_pkt(1'b0, 1'b0);
        chk("rx_ready_commit", 16'(rx_ready), 16'h0000);
        idle(1);
        chk("rx_ready_after_commit", 16'(rx_ready), 16'h0001);
        check_keys("right_cmd");

        // Hold expiry over frame ticks.
        mk(4, 8'hA5, 8'h00, 8'h01, 8'hA4);
        pkt_and_check("left_up");
        repeat (5) tick();

        // Error cases, each followed by a check that keycodes did not move.
        mk(4, 8'hA5, 8'h00, 8'h01, 8'h00);  pkt_and_check("bad_chk");
        mk(4, 8'hA5, 8'h01, 8'h01, 8'hA5);  pkt_and_check("after_bad_chk");
        mk(3, 8'h11, 8'h22, 8'h33);         pkt_and_check("bad_hdr");
        mk(4, 8'hA5, 8'h00, 8'h02, 8'hA7);  pkt_and_check("after_bad_hdr");
        mk(2, 8'hA5, 8'h00);                pkt_and_check("early_last");
        mk(5, 8'hA5, 8'h00, 8'h01, 8'hA4, 8'h55); pkt_and_check("no_last");
        mk(4, 8'hA5, 8'h00, 8'h03, 8'hA6);  pkt_and_check("bad_cmd");
        mk(4, 8'hA5, 8'h02, 8'h01, 8'hA6);  pkt_and_check("bad_player");
        mk(1, 8'hA5);                       pkt_and_check("hdr_last");

        // Commit for left coincident with a tick: left counter 1, right 2.
        repeat (4) tick();
        mk(4, 8'hA5, 8'h00, 8'h01, 8'hA4);  pkt_and_check("coin_l");
        tick();
        mk(4, 8'hA5, 8'h01, 8'h02, 8'hA6);  pkt_and_check("coin_r");
        tick();
        tick();
        mk(4, 8'hA5, 8'h00, 8'h02, 8'hA7);
        send_pkt(1'b0, 1'b1);
        idle(1);
        check_keys("coincident");
        repeat (4) tick();

        // Randomized packets with random gaps and ticks.
        repeat (150) begin
            if ($urandom_range(0, 9) < 5) begin
                p = 8'($urandom_range(0, 1));
                c = 8'($urandom_range(0, 2));
                mk(4, HDR, p, c, HDR ^ p ^ c);
            end else begin
                n = $urandom_range(1, 5);
                for (int k = 0; k < 5; k++) b[k] = 8'($urandom_range(0, 3));
                b[0] = ($urandom_range(0, 1) == 1) ? HDR : 8'($urandom);
                b[3] = ($urandom_range(0, 1) == 1) ? (b[0] ^ b[1] ^ b[2]) : 8'($urandom);
                mk(n, b[0], b[1], b[2], b[3], b[4]);
            end
            send_pkt(1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                idle(1);
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        idle(2);
        check_keys("random_end");

        // Drive the error counter to saturation, then one more error.
        while (m_err != 16'hFFFF) begin
            mk(1, 8'h00);
            send_pkt(1'b0, 1'b0);
        end
        mk(1, 8'h3C);
        send_pkt(1'b0, 1'b0);
        idle(3);
        chk("err_count_saturated", err_count, 16'hFFFF);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_cmd_rx.md
Name: paddle_cmd_rx

Overview:
- Upstream stage of the paddle motion block. Parses a received Ethernet payload byte stream into per-player paddle commands.
- Outputs two 8-bit keycodes (left and right) in the encoding the paddle block consumes: 8'h01 = up, 8'h02 = down, 8'h00 = idle.
- Each command is held for a programmable number of frame ticks, then reverts to idle, so a lost packet cannot leave a paddle moving.

Parameters:
- HDR, 8'hA5: required first byte of every command packet.
- HOLD_FRAMES, 4: frame ticks a committed command stays on its keycode output (1..255).

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- rx_data  in  8  payload byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_last  in  1  qualifies rx_data as the final byte of the packet.
- rx_ready  out  1  block accepts a byte this cycle; a transfer is rx_valid && rx_ready.
- frame_tick  in  1  one-Clk pulse per video frame, already synchronised to Clk.
- keycode_left  out  8  keycode for the left paddle.
- keycode_right  out  8  keycode for the right paddle.
- pkt_ok  out  1  one-cycle pulse on commit of a good packet.
- pkt_err  out  1  one-cycle pulse on a packet error.
- err_count  out  16  count of errors, saturating at 16'hFFFF.

Behaviour:
- Packet format, exactly 4 bytes: HDR, PLAYER, CMD, CHK.
  - PLAYER: 0 = left, 1 = right.
  - CMD: 0, 1 or 2.
  - CHK = HDR ^ PLAYER ^ CMD.
  - rx_last must be set on CHK and only on CHK.
- Reset values: FSM = IDLE; both keycodes 8'h00; both hold counters 0; pkt_ok = 0; pkt_err = 0; err_count = 0.
- Reset asserted mid-packet discards the partial packet and clears held commands.
- FSM states: IDLE, GET_PLAYER, GET_CMD, GET_CHK, COMMIT, DRAIN.
- rx_ready = 1 in every state except COMMIT.
- IDLE:
  - Byte == HDR with !rx_last -> GET_PLAYER.
  - Byte != HDR -> error. Go to IDLE if rx_last, else DRAIN.
  - Byte == HDR with rx_last -> error, stay IDLE.
- GET_PLAYER / GET_CMD:
  - Latch the byte and advance to the next state.
  - rx_last on either byte -> error, IDLE.
- GET_CHK:
  - rx_last = 0 -> error, DRAIN.
  - Else if PLAYER > 1, CMD > 2, or CHK mismatch -> error, IDLE.
  - Else -> COMMIT.
- COMMIT (one cycle, nothing accepted):
  - pkt_ok = 1.
  - Selected keycode <= CMD; selected hold counter <= HOLD_FRAMES.
  - Next state IDLE.
- DRAIN: discard bytes until a transfer with rx_last, then IDLE. No further error is counted for drained bytes.
- Latency:
  - CHK accepted in cycle N -> pkt_ok high in cycle N+1 -> new keycode visible from cycle N+2.
  - pkt_err is registered: high the cycle after the offending transfer. err_count increments on that same edge.
  - At most one error per packet.
- Hold counters (independent per player):
  - On frame_tick with counter > 0: decrement.
  - When the decrement reaches 0, the keycode is cleared to 8'h00 on that same edge.
  - A counter of 0 ignores frame_tick.
- Simultaneous COMMIT and frame_tick for the same player: commit wins (load HOLD_FRAMES, no decrement). The other player still decrements normally.
- A new command for a player overrides that player's current keycode and reloads its counter, even before expiry.
- Bytes with rx_valid = 0 are ignored; the FSM holds state.
- err_count does not wrap: at 16'hFFFF, further errors still pulse pkt_err but the count stays.

Test Plan:
- Reset low mid-packet (after A5, 00) -> all outputs 0. Then send A5 01 02 A6 with rx_last on A6 -> pkt_ok the cycle after A6; keycode_right = 8'h02 two cycles after A6; keycode_left = 00.
- Send A5 00 01 A4, then 4 frame_ticks -> keycode_left = 01 through the 3rd tick; 00 immediately after the 4th tick; a 5th tick changes nothing.
- Bad checksum A5 00 01 00 -> pkt_err pulse, err_count = 1, keycode_left unchanged. Follow with a good packet -> accepted.
- Bad header 11 22 33 with rx_last on 33 -> one pkt_err and err_count + 1. The bytes are drained, and the next A5 00 02 A7 commits keycode_left = 02.
- Early rx_last on PLAYER byte (A5 00) -> error, return to IDLE. Missing rx_last on CHK -> error and DRAIN until rx_last. Also CMD = 03 with a valid CHK -> error, no update.
- Commit for left coincident with frame_tick while left counter = 1 and right counter = 2 -> left counter = HOLD_FRAMES and keycode_left = new CMD; right counter = 1.
- Saturation: preload err_count at FFFF via 65535 error packets -> an extra error pulses pkt_err, count stays FFFF.
- rx_ready low exactly in the COMMIT cycle; a byte presented then is accepted the following cycle.
